// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter.
//   arb_state_e : arbiter FSM states (idle / request issued / awaiting response)
//   owner_e     : which requester owns the transaction in flight
//   strb_width  : byte-strobe width for a given data width
//   cnt_width   : timeout counter width able to hold 0..timeout-1
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  function automatic int unsigned strb_width(int unsigned data_w);
    return data_w / 32'd8;
  endfunction

  localparam int unsigned MEM_STRB_WIDTH = strb_width(32'd32);

  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout <= 32'd2) ? 32'd1 : 32'($clog2(timeout));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Combinational two-way grant selection between fetch and load/store.
//   if_valid_i / ls_valid_i : request valids
//   last_grant_i            : owner of the previous grant (round-robin memory)
//   grant_valid_o           : at least one requester is valid
//   grant_o                 : selected requester
// LS_PRIO=1 gives load/store fixed priority; 0 alternates on contention.
module arb_pick2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit LS_PRIO = 1'b1
) (
  input  logic   if_valid_i,
  input  logic   ls_valid_i,
  input  owner_e last_grant_i,
  output logic   grant_valid_o,
  output owner_e grant_o
);

  always_comb begin
    grant_valid_o = if_valid_i | ls_valid_i;
    grant_o       = OWN_IF;
    if (ls_valid_i && !if_valid_i) begin
      grant_o = OWN_LS;
    end else if (ls_valid_i && if_valid_i) begin
      if (LS_PRIO) begin
        grant_o = OWN_LS;
      end else begin
        grant_o = (last_grant_i == OWN_IF) ? OWN_LS : OWN_IF;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single memory port between instruction fetch (IF) and the
// load/store unit (LS). One transaction outstanding; each response is routed
// back to the requester that issued it. Supports fetch flush and a response
// timeout that completes the transaction with an error.
//   clk, rst                         : clock, synchronous active-high reset
//   if_req_* / if_resp_* / if_flush  : fetch request/response, branch cancel
//   ls_req_* / ls_resp_*             : load/store request/response
//   mem_req_* / mem_resp_*           : memory-side bus
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LS_PRIO = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_req_ready,
  input  logic                if_flush,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  output logic                if_resp_err,
  input  logic                ls_req_valid,
  input  logic                ls_req_wen,
  input  logic [ADDR_W-1:0]   ls_req_addr,
  input  logic [DATA_W-1:0]   ls_req_wdata,
  input  logic [DATA_W/8-1:0] ls_req_wstrb,
  output logic                ls_req_ready,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_resp_data,
  output logic                ls_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  localparam int unsigned STRB_W = strb_width(DATA_W);
  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_q, last_d;
  owner_e             grant;
  logic               grant_valid;
  logic               drop_q, drop_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic               resp_done;
  logic               flush_hit;

  arb_pick2 #(.LS_PRIO(LS_PRIO != 0)) u_pick (
    .if_valid_i    (if_req_valid),
    .ls_valid_i    (ls_req_valid),
    .last_grant_i  (last_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  // A response or an expired timeout both complete the RESP phase.
  assign resp_done = (state_q == ARB_RESP) && (mem_resp_valid || (tmo_q == TMO_LAST));
  assign flush_hit = (owner_q == OWN_IF) && if_flush;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (grant_valid)   state_d = ARB_REQ;
      ARB_REQ:  if (mem_req_ready) state_d = ARB_RESP;
      ARB_RESP: if (resp_done)     state_d = ARB_IDLE;
      default:                     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    drop_d  = drop_q;
    tmo_d   = tmo_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant;
          last_d  = grant;
          drop_d  = (grant == OWN_IF) && if_flush;
          if (grant == OWN_LS) begin
            wen_d   = ls_req_wen;
            addr_d  = ls_req_addr;
            wdata_d = ls_req_wdata;
            wstrb_d = ls_req_wstrb;
          end else begin
            wen_d   = 1'b0;
            addr_d  = if_req_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end
        end
      end
      ARB_REQ: begin
        if (flush_hit)     drop_d = 1'b1;
        if (mem_req_ready) tmo_d  = '0;
      end
      ARB_RESP: begin
        if (resp_done) begin
          drop_d = 1'b0;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
          if (flush_hit) drop_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      drop_q  <= 1'b0;
      tmo_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Handshake/valid outputs are masked while rst is high so nothing leaks
  // from a transaction that the reset is about to abandon. A flush arriving
  // in the completion cycle itself also suppresses the fetch response.
  always_comb begin
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    if_resp_err   = 1'b0;
    if_resp_data  = '0;
    ls_resp_valid = 1'b0;
    ls_resp_err   = 1'b0;
    ls_resp_data  = '0;
    if (!rst) begin
      if ((state_q == ARB_IDLE) && grant_valid) begin
        if_req_ready = (grant == OWN_IF);
        ls_req_ready = (grant == OWN_LS);
      end
      mem_req_valid = (state_q == ARB_REQ);
      if (resp_done) begin
        if (owner_q == OWN_LS) begin
          ls_resp_valid = 1'b1;
          ls_resp_err   = !mem_resp_valid;
          ls_resp_data  = mem_resp_valid ? mem_resp_data : '0;
        end else if (!drop_q && !if_flush) begin
          if_resp_valid = 1'b1;
          if_resp_err   = !mem_resp_valid;
          if_resp_data  = mem_resp_valid ? mem_resp_data : '0;
        end
      end
    end
  end

  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned TMO = 4;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h8000_0010;
  localparam logic [31:0] SA = 32'h8000_1000;
  localparam logic [31:0] SD = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_flush;
    logic        ls_req_valid;
    logic        ls_req_wen;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_wstrb;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
  } in_t;

  typedef struct packed {
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        if_resp_err;
    logic        ls_req_ready;
    logic        ls_resp_valid;
    logic [31:0] ls_resp_data;
    logic        ls_resp_err;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
  } out_t;

  typedef struct {
    in_t         s;
    logic        e_ifr, e_lsr, e_mv, e_mw, e_ifrv, e_lsrv, e_err;
    logic [31:0] e_ma, e_md, e_rd;
    logic [3:0]  e_ms;
  } vec_t;

  logic clk;
  in_t  vi [2];
  out_t vo [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance 0: LS fixed priority. Instance 1: round-robin.
  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic        irr, irv, ire, lrr, lrv, lre, mrv, mrw;
    logic [31:0] ird, lrd, mra, mrd;
    logic [3:0]  mrs;
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LS_PRIO((k == 0) ? 1 : 0), .TIMEOUT(TMO)) u_dut (
      .clk            (clk),
      .rst            (vi[k].rst),
      .if_req_valid   (vi[k].if_req_valid),
      .if_req_addr    (vi[k].if_req_addr),
      .if_req_ready   (irr),
      .if_flush       (vi[k].if_flush),
      .if_resp_valid  (irv),
      .if_resp_data   (ird),
      .if_resp_err    (ire),
      .ls_req_valid   (vi[k].ls_req_valid),
      .ls_req_wen     (vi[k].ls_req_wen),
      .ls_req_addr    (vi[k].ls_req_addr),
      .ls_req_wdata   (vi[k].ls_req_wdata),
      .ls_req_wstrb   (vi[k].ls_req_wstrb),
      .ls_req_ready   (lrr),
      .ls_resp_valid  (lrv),
      .ls_resp_data   (lrd),
      .ls_resp_err    (lre),
      .mem_req_valid  (mrv),
      .mem_req_ready  (vi[k].mem_req_ready),
      .mem_req_wen    (mrw),
      .mem_req_addr   (mra),
      .mem_req_wdata  (mrd),
      .mem_req_wstrb  (mrs),
      .mem_resp_valid (vi[k].mem_resp_valid),
      .mem_resp_data  (vi[k].mem_resp_data)
    );
    assign vo[k] = '{if_req_ready: irr, if_resp_valid: irv, if_resp_data: ird, if_resp_err: ire,
                     ls_req_ready: lrr, ls_resp_valid: lrv, ls_resp_data: lrd, ls_resp_err: lre,
                     mem_req_valid: mrv, mem_req_wen: mrw, mem_req_addr: mra, mem_req_wdata: mrd,
                     mem_req_wstrb: mrs};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t row(
    input int rst, input int ifv, input logic [31:0] ifa, input int fl,
    input int lsv, input int lsw, input logic [31:0] lsa, input logic [31:0] lsd, input int lss,
    input int mrdy, input int mrv, input logic [31:0] mrd,
    input int ifr, input int lsr, input int mv, input logic [31:0] ma, input int mw,
    input logic [31:0] md, input int ms, input int ifrv, input int lsrv,
    input logic [31:0] rd, input int err);
    vec_t v;
    v.s = '{rst: rst != 0, if_req_valid: ifv != 0, if_req_addr: ifa, if_flush: fl != 0,
            ls_req_valid: lsv != 0, ls_req_wen: lsw != 0, ls_req_addr: lsa, ls_req_wdata: lsd,
            ls_req_wstrb: 4'(lss), mem_req_ready: mrdy != 0, mem_resp_valid: mrv != 0,
            mem_resp_data: mrd};
    v.e_ifr = ifr != 0;  v.e_lsr = lsr != 0;  v.e_mv = mv != 0;  v.e_ma = ma;
    v.e_mw = mw != 0;    v.e_md = md;         v.e_ms = 4'(ms);
    v.e_ifrv = ifrv != 0; v.e_lsrv = lsrv != 0; v.e_rd = rd; v.e_err = err != 0;
    return v;
  endfunction

  task automatic apply_row(input int n, input vec_t v);
    vi[0] = v.s;
    @(negedge clk);
    chk1($sformatf("row%0d if_req_ready", n), vo[0].if_req_ready, v.e_ifr);
    chk1($sformatf("row%0d ls_req_ready", n), vo[0].ls_req_ready, v.e_lsr);
    chk1($sformatf("row%0d mem_req_valid", n), vo[0].mem_req_valid, v.e_mv);
    if (v.e_mv) begin
      chk32($sformatf("row%0d mem_req_addr", n), vo[0].mem_req_addr, v.e_ma);
      chk1($sformatf("row%0d mem_req_wen", n), vo[0].mem_req_wen, v.e_mw);
      chk32($sformatf("row%0d mem_req_wdata", n), vo[0].mem_req_wdata, v.e_md);
      chk32($sformatf("row%0d mem_req_wstrb", n), 32'(vo[0].mem_req_wstrb), 32'(v.e_ms));
    end
    chk1($sformatf("row%0d if_resp_valid", n), vo[0].if_resp_valid, v.e_ifrv);
    chk1($sformatf("row%0d ls_resp_valid", n), vo[0].ls_resp_valid, v.e_lsrv);
    chk1($sformatf("row%0d if_resp_err", n), vo[0].if_resp_err, v.e_ifrv && v.e_err);
    chk1($sformatf("row%0d ls_resp_err", n), vo[0].ls_resp_err, v.e_lsrv && v.e_err);
    if (v.e_ifrv) chk32($sformatf("row%0d if_resp_data", n), vo[0].if_resp_data, v.e_rd);
    if (v.e_lsrv) chk32($sformatf("row%0d ls_resp_data", n), vo[0].ls_resp_data, v.e_rd);
    step();
  endtask

  // Reference model: transaction-level view per instance.
  // phase 0 = free, 1 = request offered to memory, 2 = waiting for data.
  int          m_phase [2], m_own [2], m_last [2], m_wait [2], m_g [2];
  bit          m_drop [2], m_done [2];
  logic        m_wen [2];
  logic [31:0] m_addr [2], m_wdata [2];
  logic [3:0]  m_wstrb [2];

  task automatic model_check(input int k);
    in_t  x = vi[k];
    out_t y = vo[k];
    bit   killed, exp_if, exp_ls;
    m_g[k] = -1;
    if (!x.rst && m_phase[k] == 0) begin
      if (x.if_req_valid && x.ls_req_valid) m_g[k] = (k == 0 || m_last[k] == 0) ? 1 : 0;
      else if (x.ls_req_valid) m_g[k] = 1;
      else if (x.if_req_valid) m_g[k] = 0;
    end
    chk1($sformatf("rnd k%0d if_req_ready", k), y.if_req_ready, m_g[k] == 0);
    chk1($sformatf("rnd k%0d ls_req_ready", k), y.ls_req_ready, m_g[k] == 1);
    chk1($sformatf("rnd k%0d mem_req_valid", k), y.mem_req_valid, !x.rst && m_phase[k] == 1);
    if (!x.rst && m_phase[k] == 1) begin
      chk32($sformatf("rnd k%0d mem_req_addr", k), y.mem_req_addr, m_addr[k]);
      chk1($sformatf("rnd k%0d mem_req_wen", k), y.mem_req_wen, m_wen[k]);
      chk32($sformatf("rnd k%0d mem_req_wdata", k), y.mem_req_wdata, m_wdata[k]);
      chk32($sformatf("rnd k%0d mem_req_wstrb", k), 32'(y.mem_req_wstrb), 32'(m_wstrb[k]));
    end
    m_done[k] = !x.rst && m_phase[k] == 2 && (x.mem_resp_valid || (m_wait[k] + 1 == TMO));
    killed = m_own[k] == 0 && (m_drop[k] || x.if_flush);
    exp_if = m_done[k] && m_own[k] == 0 && !killed;
    exp_ls = m_done[k] && m_own[k] == 1;
    chk1($sformatf("rnd k%0d if_resp_valid", k), y.if_resp_valid, exp_if);
    chk1($sformatf("rnd k%0d ls_resp_valid", k), y.ls_resp_valid, exp_ls);
    chk1($sformatf("rnd k%0d if_resp_err", k), y.if_resp_err, exp_if && !x.mem_resp_valid);
    chk1($sformatf("rnd k%0d ls_resp_err", k), y.ls_resp_err, exp_ls && !x.mem_resp_valid);
    if (exp_if) chk32($sformatf("rnd k%0d if_resp_data", k), y.if_resp_data, x.mem_resp_valid ? x.mem_resp_data : Z);
    if (exp_ls) chk32($sformatf("rnd k%0d ls_resp_data", k), y.ls_resp_data, x.mem_resp_valid ? x.mem_resp_data : Z);
  endtask

  task automatic model_step(input int k);
    in_t x = vi[k];
    if (x.rst) begin
      m_phase[k] = 0; m_own[k] = 0; m_last[k] = 0; m_drop[k] = 0; m_wait[k] = 0;
      m_wen[k] = 0; m_addr[k] = Z; m_wdata[k] = Z; m_wstrb[k] = 4'h0;
    end else if (m_phase[k] == 0) begin
      if (m_g[k] >= 0) begin
        m_own[k] = m_g[k]; m_last[k] = m_g[k]; m_phase[k] = 1;
        m_drop[k] = m_g[k] == 0 && x.if_flush;
        m_wen[k]   = (m_g[k] == 1) ? x.ls_req_wen : 1'b0;
        m_addr[k]  = (m_g[k] == 1) ? x.ls_req_addr : x.if_req_addr;
        m_wdata[k] = (m_g[k] == 1) ? x.ls_req_wdata : Z;
        m_wstrb[k] = (m_g[k] == 1) ? x.ls_req_wstrb : 4'h0;
      end
    end else if (m_phase[k] == 1) begin
      if (m_own[k] == 0 && x.if_flush) m_drop[k] = 1;
      if (x.mem_req_ready) begin m_phase[k] = 2; m_wait[k] = 0; end
    end else begin
      if (m_done[k]) begin
        m_phase[k] = 0; m_drop[k] = 0;
      end else begin
        m_wait[k]++;
        if (m_own[k] == 0 && x.if_flush) m_drop[k] = 1;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    for (int k = 0; k < 2; k++) begin vi[k] = '0; vi[k].rst = 1'b1; end
    step();
    step();
    for (int k = 0; k < 2; k++) vi[k].rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk1($sformatf("reset k%0d mem_req_valid", k), vo[k].mem_req_valid, 1'b0);
      chk32($sformatf("reset k%0d mem_req_addr", k), vo[k].mem_req_addr, Z);
      chk1($sformatf("reset k%0d if_req_ready", k), vo[k].if_req_ready, 1'b0);
      chk1($sformatf("reset k%0d ls_resp_valid", k), vo[k].ls_resp_valid, 1'b0);
    end
    step();

    // Directed vectors on instance 0 (LS priority, TIMEOUT=4).
    tbl.push_back(row(1,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,1,A0,0, 0,0,Z,Z,0, 0,0,Z,                1,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,A0,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,1,32'h13,            0,0,0,Z,0,Z,0, 1,0,32'h13,0));
    tbl.push_back(row(0,1,A1,0, 1,1,SA,SD,15, 0,0,Z,             0,1,0,Z,0,Z,0, 0,0,Z,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(row(0,1,A1,0, 0,0,Z,Z,0, 0,0,Z,              0,0,1,SA,1,SD,15, 0,0,Z,0));
    tbl.push_back(row(0,1,A1,0, 0,0,Z,Z,0, 1,0,Z,                0,0,1,SA,1,SD,15, 0,0,Z,0));
    tbl.push_back(row(0,1,A1,0, 0,0,Z,Z,0, 0,1,32'hA5A5A5A5,     0,0,0,Z,0,Z,0, 0,1,32'hA5A5A5A5,0));
    tbl.push_back(row(0,1,A1,0, 0,0,Z,Z,0, 0,0,Z,                1,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,A1,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,1,32'h00100073,      0,0,0,Z,0,Z,0, 1,0,32'h00100073,0));
    tbl.push_back(row(0,0,Z,0, 1,0,32'h100,Z,0, 0,0,Z,           0,1,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,32'h100,0,Z,0, 0,0,Z,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,               0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,1,Z,1));
    tbl.push_back(row(0,1,32'h200,0, 0,0,Z,Z,0, 0,0,Z,           1,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,32'h200,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(1,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,1,32'h55,            0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,1,32'h300,0, 0,0,Z,Z,0, 0,0,Z,           1,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,32'h300,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,1, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,1,32'h12345678,      0,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,1,32'h304,0, 0,0,Z,Z,0, 0,0,Z,           1,0,0,Z,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 1,0,Z,                 0,0,1,32'h304,0,Z,0, 0,0,Z,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,1,32'hCAFEF00D,      0,0,0,Z,0,Z,0, 1,0,32'hCAFEF00D,0));
    tbl.push_back(row(0,0,Z,0, 0,0,Z,Z,0, 0,0,Z,                 0,0,0,Z,0,Z,0, 0,0,Z,0));
    foreach (tbl[i]) apply_row(i, tbl[i]);

    // Round-robin on instance 1: an LS-only transaction leaves last grant = LS,
    // then three contending requests must be granted IF, LS, IF.
    vi[1].ls_req_valid = 1'b1;
    @(negedge clk);
    chk1("rr warmup ls_req_ready", vo[1].ls_req_ready, 1'b1);
    step();
    vi[1].ls_req_valid = 1'b0; vi[1].mem_req_ready = 1'b1;
    step();
    vi[1].mem_req_ready = 1'b0; vi[1].mem_resp_valid = 1'b1; vi[1].mem_resp_data = 32'h1;
    @(negedge clk);
    chk1("rr warmup ls_resp_valid", vo[1].ls_resp_valid, 1'b1);
    step();
    vi[1].mem_resp_valid = 1'b0;
    vi[1].if_req_valid = 1'b1; vi[1].if_req_addr = 32'h400;
    vi[1].ls_req_valid = 1'b1; vi[1].ls_req_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("rr%0d if_req_ready", i), vo[1].if_req_ready, i != 1);
      chk1($sformatf("rr%0d ls_req_ready", i), vo[1].ls_req_ready, i == 1);
      step();
      vi[1].mem_req_ready = 1'b1;
      @(negedge clk);
      chk32($sformatf("rr%0d mem_req_addr", i), vo[1].mem_req_addr, (i == 1) ? 32'h500 : 32'h400);
      chk1($sformatf("rr%0d ready while busy", i), vo[1].if_req_ready | vo[1].ls_req_ready, 1'b0);
      step();
      vi[1].mem_req_ready = 1'b0; vi[1].mem_resp_valid = 1'b1; vi[1].mem_resp_data = 32'h77 + i;
      @(negedge clk);
      chk1($sformatf("rr%0d if_resp_valid", i), vo[1].if_resp_valid, i != 1);
      chk1($sformatf("rr%0d ls_resp_valid", i), vo[1].ls_resp_valid, i == 1);
      step();
      vi[1].mem_resp_valid = 1'b0;
    end

    // Randomised run on both instances against the reference model.
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        vi[k].rst            = (c == 0) || ($urandom % 100) == 0;
        vi[k].if_req_valid   = ($urandom % 2) == 0;
        vi[k].if_req_addr    = $urandom;
        vi[k].if_flush       = ($urandom % 8) == 0;
        vi[k].ls_req_valid   = ($urandom % 2) == 0;
        vi[k].ls_req_wen     = ($urandom % 2) == 0;
        vi[k].ls_req_addr    = $urandom;
        vi[k].ls_req_wdata   = $urandom;
        vi[k].ls_req_wstrb   = 4'($urandom);
        vi[k].mem_req_ready  = ($urandom % 2) == 0;
        vi[k].mem_resp_valid = ($urandom % 3) == 0;
        vi[k].mem_resp_data  = $urandom;
      end
      @(negedge clk);
      model_check(0);
      model_check(1);
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
